// File: rtl/mem_io_ctrl_pkg.sv
// Shared constants and address decode for the memory/IO controller.
// IO window sits at 0x30000; only address bits 17:0 take part in decode.
package mem_io_ctrl_pkg;

    localparam int DEC_MSB = 17;
    localparam int DEC_LSB = 16;
    localparam logic [1:0] DEC_IO = 2'b11;

    localparam logic [17:0] IO_UART_ADDR = 18'h30000;
    localparam logic [17:0] IO_CNT_ADDR  = 18'h30004;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_IO,
        REGION_NONE
    } region_e;

    function automatic region_e decode_region(input logic [17:0] a);
        if (a[DEC_MSB:DEC_LSB] == DEC_IO) begin
            return REGION_IO;
        end else if (!a[DEC_MSB]) begin
            return REGION_RAM;
        end else begin
            return REGION_NONE;
        end
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU bus, UART TX/RX byte streams and halt flag bundled for the controller.
// The slave side is the controller; the master side is the CPU/UART environment.
interface mem_io_ctrl_if;

    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;

    logic        halt;

    modport slave (
        input  mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        output mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );

    modport master (
        output mem_a, mem_wr, mem_dout, tx_ready, rx_valid, rx_data,
        input  mem_din, io_buffer_full, tx_valid, tx_data, rx_ready, halt
    );

endinterface

// File: rtl/mem_io_ctrl_byte_fifo.sv
// Byte-wide synchronous FIFO; DEPTH must be a power of two.
// A pop frees a slot in the same cycle, so push+pop while full is accepted.
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; an empty count makes stale bytes unreachable.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// CPU-side memory/IO controller: byte RAM, UART TX FIFO and RX port,
// free-running cycle counter with snapshot readout, and sticky halt flag.
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 17,
    parameter int TX_DEPTH      = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         rdy_in,
    mem_io_ctrl_if.slave bus
);

    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] NEAR_FULL = CW'(TX_DEPTH - 2);

    logic [17:0]              addr;
    logic [RAM_ADDR_BITS-1:0] ram_idx;
    region_e                  region;
    logic                     unused_addr_bits;

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic [7:0]  io_rd_q, io_rd_d;
    logic [7:0]  ram_rd_q;
    logic        sel_ram_q;
    logic        halt_q, halt_d;
    logic        full_q, full_d;

    logic        rd_en, ram_we, ram_re;
    logic        rx_take, push;
    logic [7:0]  push_data;
    logic [7:0]  tx_head;
    logic        tx_empty, unused_tx_full;
    logic [CW-1:0] tx_count;

    logic [7:0]  ram [2**RAM_ADDR_BITS];

    assign addr             = bus.mem_a[17:0];
    assign ram_idx          = bus.mem_a[RAM_ADDR_BITS-1:0];
    assign region           = decode_region(addr);
    assign unused_addr_bits = ^bus.mem_a[31:18];

    assign rd_en  = rdy_in & ~bus.mem_wr;
    assign ram_we = rdy_in & bus.mem_wr & (region == REGION_RAM);
    assign ram_re = rd_en & (region == REGION_RAM);
    assign cnt_d  = cnt_q + 32'd1;
    assign full_d = (tx_count >= NEAR_FULL);

    always_comb begin
        io_rd_d   = 8'h00;
        snap_d    = snap_q;
        rx_take   = 1'b0;
        push      = 1'b0;
        push_data = 8'h00;
        halt_d    = halt_q;
        if (rdy_in && region == REGION_IO) begin
            if (!bus.mem_wr) begin
                case (addr)
                    IO_UART_ADDR: begin
                        if (bus.rx_valid) begin
                            io_rd_d = bus.rx_data;
                            rx_take = 1'b1;
                        end
                    end
                    IO_CNT_ADDR: begin
                        io_rd_d = cnt_q[7:0];
                        snap_d  = cnt_q;
                    end
                    IO_CNT_ADDR + 18'd1: io_rd_d = snap_q[15:8];
                    IO_CNT_ADDR + 18'd2: io_rd_d = snap_q[23:16];
                    IO_CNT_ADDR + 18'd3: io_rd_d = snap_q[31:24];
                    default: io_rd_d = 8'h00;
                endcase
            end else begin
                case (addr)
                    IO_UART_ADDR: begin
                        if (bus.mem_dout != 8'h00) begin
                            push      = 1'b1;
                            push_data = bus.mem_dout;
                        end
                    end
                    // Halt also emits a NUL so the host sees the stop in-band.
                    IO_CNT_ADDR: begin
                        halt_d    = 1'b1;
                        push      = 1'b1;
                        push_data = 8'h00;
                    end
                    default: push = 1'b0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            io_rd_q   <= 8'h00;
            sel_ram_q <= 1'b0;
            halt_q    <= 1'b0;
            full_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
            halt_q <= halt_d;
            full_q <= full_d;
            if (rd_en) begin
                io_rd_q   <= io_rd_d;
                sel_ram_q <= (region == REGION_RAM);
            end
        end
    end

    // Plain single-port array so synthesis maps it to block RAM.
    always_ff @(posedge clk_in) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.mem_dout;
        end else if (ram_re) begin
            ram_rd_q <= ram[ram_idx];
        end
    end

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_in),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (bus.tx_ready),
        .dout_o  (tx_head),
        .full_o  (unused_tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    assign bus.mem_din        = sel_ram_q ? ram_rd_q : io_rd_q;
    assign bus.io_buffer_full = full_q;
    assign bus.tx_valid       = ~tx_empty;
    assign bus.tx_data        = tx_head;
    assign bus.rx_ready       = rx_take & rst_in;
    assign bus.halt           = halt_q;

endmodule
